// File: rtl/fpu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pipe_pkg
// Shared types and constants for the FPU ID/EX issue logic.
//   ASIZE         : FPU register address width (32 registers)
//   DSIZE         : FPU data width
//   tag_t         : in-flight tag {valid, destination register}
//   issue_state_t : issue controller operating mode
// ---------------------------------------------------------------------------
package fpu_pipe_pkg;

  localparam int ASIZE = 5;
  localparam int DSIZE = 32;

  typedef struct packed {
    logic             valid;
    logic [ASIZE-1:0] rd;
  } tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } issue_state_t;

endpackage

// File: rtl/fpu_tag_delay.sv
// ---------------------------------------------------------------------------
// fpu_tag_delay
// Fixed-latency shift register of destination tags. A tag loaded at the
// head in cycle T is presented on the tail output in cycle T+EX_LAT. The
// tail output comes straight from the last register stage.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, empties every stage
//   i_tag  : tag entering the head this cycle
//   o_tag  : tag leaving the tail (registered)
// ---------------------------------------------------------------------------
module fpu_tag_delay
  import fpu_pipe_pkg::*;
#(
  parameter int EX_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag
);

  tag_t r_stage [EX_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < EX_LAT; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < EX_LAT; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[EX_LAT-1];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fpu_issue_ctrl
// Issue / hazard controller for the FPU ID/EX pipeline buffer. Each cycle it
// decides whether the decoded instruction enters ID/EX or a bubble is
// inserted, tracks pending destinations in a scoreboard fed by a
// fixed-latency tag delay line, and offers a drain handshake.
//
// Optional feature macro: FPU_BYPASS_EN
//   defined   : a register whose busy bit is being cleared by this cycle's
//               writeback is not treated as a hazard (issue in retire cycle)
//   undefined : hazards use the registered scoreboard only
//
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   id_valid         : decode holds a valid instruction
//   id_rd            : destination register
//   id_rs_l, id_rs_r : source registers
//   ex_ready         : execute stage can accept
//   drain_req        : level request to empty the pipe
//   issue            : instruction accepted this cycle (combinational)
//   stall_id         : id_valid & ~issue (combinational)
//   ex_valid         : registered issue, 0 marks an ID/EX bubble
//   wb_valid, wb_rd  : registered retiring tag
//   busy_vec         : scoreboard, bit n = register n pending
//   inflight         : outstanding op count
//   drain_done       : one-cycle pulse when a drain completes
// ---------------------------------------------------------------------------
module fpu_issue_ctrl
  import fpu_pipe_pkg::*;
#(
  parameter int EX_LAT       = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [ASIZE-1:0]      id_rd,
  input  logic [ASIZE-1:0]      id_rs_l,
  input  logic [ASIZE-1:0]      id_rs_r,
  input  logic                  ex_ready,
  input  logic                  drain_req,
  output logic                  issue,
  output logic                  stall_id,
  output logic                  ex_valid,
  output logic                  wb_valid,
  output logic [ASIZE-1:0]      wb_rd,
  output logic [2**ASIZE-1:0]   busy_vec,
  output logic [3:0]            inflight,
  output logic                  drain_done
);

  localparam int NREG = 2**ASIZE;

  issue_state_t      r_state;
  issue_state_t      w_state_next;
  logic              r_drain_done;
  logic              w_drain_done_next;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_next;
  logic [NREG-1:0]   w_set_vec;
  logic [NREG-1:0]   w_clr_vec;
  logic [NREG-1:0]   w_busy_eff;
  logic [3:0]        r_inflight;
  logic [3:0]        w_inflight_next;
  logic              r_ex_valid;
  logic              w_hazard;
  logic              w_issue;
  tag_t              w_head;
  tag_t              w_tail;

  // Tag delay line: the tail register is the writeback output.
  assign w_head = '{valid: w_issue, rd: id_rd};

  fpu_tag_delay #(
    .EX_LAT (EX_LAT)
  ) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_head),
    .o_tag (w_tail)
  );

  // Per-register set/clear decode; set wins over a same-cycle clear.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      assign w_set_vec[gi]   = w_issue     & (id_rd     == ASIZE'(gi));
      assign w_clr_vec[gi]   = w_tail.valid & (w_tail.rd == ASIZE'(gi));
      assign w_busy_next[gi] = w_set_vec[gi] | (r_busy[gi] & ~w_clr_vec[gi]);
    end
  endgenerate

`ifdef FPU_BYPASS_EN
  // A register retiring this cycle is already safe to read or rewrite.
  assign w_busy_eff = r_busy & ~w_clr_vec;
`else
  assign w_busy_eff = r_busy;
`endif

  // RAW on either source, WAW on the destination.
  assign w_hazard = w_busy_eff[id_rs_l] | w_busy_eff[id_rs_r] | w_busy_eff[id_rd];

  assign w_issue = id_valid & ~w_hazard & ex_ready &
                   (r_inflight < 4'(MAX_INFLIGHT)) & (r_state == RUN);

  always_comb begin
    w_inflight_next = r_inflight;
    case ({w_issue, w_tail.valid})
      2'b10:   w_inflight_next = r_inflight + 4'd1;
      2'b01:   w_inflight_next = r_inflight - 4'd1;
      default: w_inflight_next = r_inflight;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_inflight <= '0;
      r_ex_valid <= 1'b0;
    end else begin
      r_busy     <= w_busy_next;
      r_inflight <= w_inflight_next;
      r_ex_valid <= w_issue;
    end
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_drain_done <= w_drain_done_next;
    end
  end

  // Nothing issues in DRAIN, so the pipe is empty at the next edge as soon
  // as the count after this cycle's retirement reaches zero. Entering DONE
  // on that edge makes drain_done land one cycle after the last wb_valid.
  always_comb begin
    w_state_next      = r_state;
    w_drain_done_next = 1'b0;
    case (r_state)
      RUN: begin
        if (drain_req) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_inflight_next == 4'd0) begin
          w_state_next      = DONE;
          w_drain_done_next = 1'b1;
        end
      end
      DONE: begin
        if (!drain_req) w_state_next = RUN;
      end
      default: w_state_next = RUN;
    endcase
  end

  assign issue      = w_issue;
  assign stall_id   = id_valid & ~w_issue;
  assign ex_valid   = r_ex_valid;
  assign wb_valid   = w_tail.valid;
  assign wb_rd      = w_tail.rd;
  assign busy_vec   = r_busy;
  assign inflight   = r_inflight;
  assign drain_done = r_drain_done;

endmodule
